read_arbiter: RTL and testbench
===============================

READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of requesting output channels (2..8).
REQ-002 SHALL have parameter ADDRESS_BUS_WIDTH, default 16, width of every address bus.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of cycles to wait for memory completion.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_address  input  CHANNELS*ADDRESS_BUS_WIDTH  per-channel word address; channel i occupies slice i.
REQ-007 SHALL have port req_read_request  input  CHANNELS  per-channel level request (the channel's FIFO is not full).
REQ-008 SHALL have port req_read_data  output  16  returned word, broadcast to all channels.
REQ-009 SHALL have port req_read_finished_strobe  output  CHANNELS  one-cycle, one-hot data-valid strobe to the granted channel.
REQ-010 SHALL have port mem_address  output  ADDRESS_BUS_WIDTH  address presented to the shared memory.
REQ-011 SHALL have port mem_read_strobe  output  1  one-cycle read command.
REQ-012 SHALL have port mem_read_data  input  16  memory data, valid while mem_read_done is high.
REQ-013 SHALL have port mem_read_done  input  1  one-cycle memory completion strobe.
REQ-014 SHALL have port grant  output  $clog2(CHANNELS)  index of the channel currently or last served.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port timeout_error  output  1  sticky flag, set on any timeout.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and DELIVER.
REQ-018 IDLE: if any req_read_request bit is high, SHALL select a channel round-robin, starting at (last grant + 1) mod CHANNELS, register its index and address, and go to ISSUE.
REQ-019 ISSUE: SHALL drive mem_read_strobe high for exactly one cycle with mem_address equal to the latched address, clear the timeout counter, and go to WAIT.
REQ-020 WAIT: on mem_read_done, SHALL capture mem_read_data into the output register and go to DELIVER.
REQ-021 WAIT: if no done arrives, SHALL increment the timeout counter; when it reaches TIMEOUT_CYCLES, SHALL set timeout_error, issue no strobe, and return to IDLE.
REQ-022 DELIVER: SHALL pulse req_read_finished_strobe[grant] for one cycle with req_read_data stable, then return to IDLE.
REQ-023 A request-to-strobe round trip SHALL take 3 cycles plus the memory latency; at most one memory transaction SHALL be outstanding.
REQ-024 The address SHALL be latched in IDLE, so later changes to req_address SHALL NOT affect an in-flight read.
REQ-025 Request deassertion after grant SHALL NOT cancel the read; the strobe is still delivered.
REQ-026 A mem_read_done outside WAIT SHALL be ignored.
REQ-027 A done arriving in the same cycle the timeout expires SHALL be accepted as a completion, and timeout_error SHALL NOT be set.
REQ-028 Round-robin SHALL wrap from CHANNELS-1 to 0; a single persistent requester SHALL be served back-to-back.
REQ-029 req_read_data SHALL hold its last value between deliveries.

Reset
REQ-030 When rst is low, SHALL asynchronously force: state IDLE, mem_read_strobe 0, mem_address 0, req_read_finished_strobe 0, req_read_data 0, grant CHANNELS-1 (so channel 0 wins first), busy 0, timeout_error 0, timeout counter 0.
REQ-031 Reset mid-transaction SHALL abandon the read; no strobe SHALL be emitted for it after reset releases.
REQ-032 timeout_error SHALL be cleared only by reset.

Structure
REQ-033 The state encoding and the default TIMEOUT_CYCLES SHALL live in a shared package with the other output-block constants.
REQ-034 The round-robin selector SHALL be one sub-module, rr_select: request vector plus last grant in, index plus valid out, purely combinational.

Verification
REQ-035 A bench SHALL cover: after reset, single request on ch2 with address 0x0123, memory latency 2, data 0xBEEF -> mem_read_strobe with 0x0123, then strobe[2] with 0xBEEF 5 cycles after grant.
REQ-036 A bench SHALL cover: all four channels requesting continuously -> grants 0,1,2,3,0 in order, with no channel served twice before another.
REQ-037 A bench SHALL cover: a memory that never responds with TIMEOUT_CYCLES=8 -> timeout_error high after 8 WAIT cycles, no finished strobe, and the arbiter serves the next channel.
REQ-038 A bench SHALL cover: done in the same cycle as the timeout expiry -> data delivered, timeout_error stays 0.
REQ-039 A bench SHALL cover: rst asserted during WAIT, then done arrives after release -> no finished strobe, all outputs at reset values.
REQ-040 A bench SHALL cover: req_address changed and request dropped during WAIT -> original address used and the strobe still delivered.

Source files
------------

// File: rtl/read_arbiter_pkg.sv
// read_arbiter_pkg: shared types and constants for the read arbiter slice.
//   state_t                 - arbiter FSM encoding
//   DATA_WIDTH              - width of the memory / channel data word
//   MAX_CHANNELS            - upper bound on the channel count
//   DEFAULT_*               - default parameter values for the top level
//   onehot_idx()            - index to one-hot strobe vector helper
package read_arbiter_pkg;

    localparam int DATA_WIDTH                = 16;
    localparam int MAX_CHANNELS              = 8;
    localparam int DEFAULT_CHANNELS          = 4;
    localparam int DEFAULT_ADDRESS_BUS_WIDTH = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES    = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // Converts a channel index into a one-hot vector sized for the largest configuration.
    function automatic logic [MAX_CHANNELS-1:0] onehot_idx(input logic [2:0] idx);
        onehot_idx = {{(MAX_CHANNELS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/read_arbiter_if.sv
// read_arbiter_if: bundle of the channel-side and memory-side signals of the arbiter.
//   master modport - seen by the arbiter (drives data/strobes/address/status)
//   slave  modport - seen by the channels + memory environment
interface read_arbiter_if
    import read_arbiter_pkg::*;
#(
    parameter int CHANNELS          = DEFAULT_CHANNELS,
    parameter int ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH
);
    localparam int GRANT_W = $clog2(CHANNELS);

    logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] req_address;
    logic [CHANNELS-1:0]                   req_read_request;
    logic [DATA_WIDTH-1:0]                 req_read_data;
    logic [CHANNELS-1:0]                   req_read_finished_strobe;
    logic [ADDRESS_BUS_WIDTH-1:0]          mem_address;
    logic                                  mem_read_strobe;
    logic [DATA_WIDTH-1:0]                 mem_read_data;
    logic                                  mem_read_done;
    logic [GRANT_W-1:0]                    grant;
    logic                                  busy;
    logic                                  timeout_error;

    modport master (
        input  req_address, req_read_request, mem_read_data, mem_read_done,
        output req_read_data, req_read_finished_strobe, mem_address, mem_read_strobe,
               grant, busy, timeout_error
    );

    modport slave (
        output req_address, req_read_request, mem_read_data, mem_read_done,
        input  req_read_data, req_read_finished_strobe, mem_address, mem_read_strobe,
               grant, busy, timeout_error
    );

endinterface

// File: rtl/read_arbiter_rr_select.sv
// rr_select: combinational round-robin pick.
//   i_req   - request vector, one bit per channel
//   i_last  - index of the channel served last
//   o_idx   - first requesting channel after i_last (wrapping)
//   o_valid - at least one channel is requesting
// Channels above i_last have priority (lowest first); otherwise the lowest
// channel at or below i_last wins, which realises the wrap to channel 0.
module rr_select #(
    parameter int CHANNELS = 4,
    parameter int GRANT_W  = 2
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [GRANT_W-1:0]  i_last,
    output logic [GRANT_W-1:0]  o_idx,
    output logic                o_valid
);

    logic [GRANT_W-1:0] w_idx_hi;
    logic [GRANT_W-1:0] w_idx_lo;
    logic               w_found_hi;

    // Scan downwards so the lowest qualifying channel in each half is the one kept.
    always_comb begin
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        w_found_hi = 1'b0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (i_req[j] && (GRANT_W'(j) > i_last)) begin
                w_idx_hi   = GRANT_W'(j);
                w_found_hi = 1'b1;
            end else if (i_req[j]) begin
                w_idx_lo = GRANT_W'(j);
            end else begin
                w_idx_lo = w_idx_lo;
            end
        end
    end

    // Merge the two halves.
    always_comb begin
        o_valid = |i_req;
        o_idx   = w_found_hi ? w_idx_hi : w_idx_lo;
    end

endmodule

// File: rtl/read_arbiter.sv
// read_arbiter: round-robin arbiter granting per-channel read requests access
// to a single shared memory, one transaction outstanding at a time.
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - read_arbiter_if.master: channel requests/addresses in, broadcast data
//          and one-hot finished strobe out, memory command out / response in,
//          grant/busy/timeout_error status out.
// Sequence per transaction: IDLE (pick + latch) -> ISSUE (command strobe)
// -> WAIT (until done or timeout) -> DELIVER (finished strobe) -> IDLE.
module read_arbiter
    import read_arbiter_pkg::*;
#(
    parameter int CHANNELS          = DEFAULT_CHANNELS,
    parameter int ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH,
    parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES
) (
    input logic         clk,
    input logic         rst,
    read_arbiter_if.master bus
);

    localparam int GRANT_W = $clog2(CHANNELS);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t                       r_state;
    logic [GRANT_W-1:0]           r_grant;
    logic [ADDRESS_BUS_WIDTH-1:0] r_mem_address;
    logic                         r_mem_read_strobe;
    logic [DATA_WIDTH-1:0]        r_read_data;
    logic [CHANNELS-1:0]          r_finished;
    logic                         r_busy;
    logic                         r_timeout_error;
    logic [CNT_W-1:0]             r_count;

    logic [GRANT_W-1:0]           w_sel_idx;
    logic                         w_sel_valid;
    logic [ADDRESS_BUS_WIDTH-1:0] w_sel_addr;
    logic [MAX_CHANNELS-1:0]      w_onehot_full;
    logic [CHANNELS-1:0]          w_onehot;

    rr_select #(
        .CHANNELS (CHANNELS),
        .GRANT_W  (GRANT_W)
    ) u_rr_select (
        .i_req   (bus.req_read_request),
        .i_last  (r_grant),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    // Address mux for the selected channel; constant slices keep the indexing static.
    always_comb begin
        w_sel_addr = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            w_sel_addr = (w_sel_idx == GRANT_W'(j))
                       ? bus.req_address[j*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH]
                       : w_sel_addr;
        end
    end

    // One-hot finished strobe for the channel currently granted.
    always_comb begin
        w_onehot_full = onehot_idx(3'(r_grant));
        w_onehot      = w_onehot_full[CHANNELS-1:0];
    end

    // Arbiter FSM with all outputs registered; command and finished strobes
    // default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_grant           <= GRANT_W'(CHANNELS - 1);
            r_mem_address     <= '0;
            r_mem_read_strobe <= 1'b0;
            r_read_data       <= '0;
            r_finished        <= '0;
            r_busy            <= 1'b0;
            r_timeout_error   <= 1'b0;
            r_count           <= '0;
        end else begin
            r_mem_read_strobe <= 1'b0;
            r_finished        <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        // Latching here keeps later address changes out of the in-flight read.
                        r_grant           <= w_sel_idx;
                        r_mem_address     <= w_sel_addr;
                        r_mem_read_strobe <= 1'b1;
                        r_busy            <= 1'b1;
                        r_state           <= ST_ISSUE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_count <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done takes priority, so a done in the expiry cycle still completes.
                    if (bus.mem_read_done) begin
                        r_read_data <= bus.mem_read_data;
                        r_finished  <= w_onehot;
                        r_state     <= ST_DELIVER;
                    end else if (r_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_error <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_DELIVER: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_read_data            = r_read_data;
    assign bus.req_read_finished_strobe = r_finished;
    assign bus.mem_address              = r_mem_address;
    assign bus.mem_read_strobe          = r_mem_read_strobe;
    assign bus.grant                    = r_grant;
    assign bus.busy                     = r_busy;
    assign bus.timeout_error            = r_timeout_error;

endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter: directed self-checking bench for read_arbiter
// (4 channels, 16-bit addresses, TIMEOUT_CYCLES = 8).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// Memory latency L here means the number of WAIT cycles that pass before the
// cycle in which mem_read_done is driven high.
module tb_read_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic r_fin_seen;

    read_arbiter_if #(.CHANNELS(4), .ADDRESS_BUS_WIDTH(16)) bus ();

    read_arbiter #(
        .CHANNELS          (4),
        .ADDRESS_BUS_WIDTH (16),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (bus.mem_read_strobe) seen = 1'b1;
        end
        check("mem_strobe_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(bus.busy),                     32'd0);
        check({tag, "_grant"},    32'(bus.grant),                    32'd3);
        check({tag, "_mstrobe"},  32'(bus.mem_read_strobe),          32'd0);
        check({tag, "_maddr"},    32'(bus.mem_address),              32'h0);
        check({tag, "_fin"},      32'(bus.req_read_finished_strobe), 32'h0);
        check({tag, "_data"},     32'(bus.req_read_data),            32'h0);
        check({tag, "_timeout"},  32'(bus.timeout_error),            32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.req_address      = '0;
        bus.req_read_request = '0;
        bus.mem_read_data    = '0;
        bus.mem_read_done    = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Single request on ch2, address 0x0123, latency 2, data 0xBEEF
        bus.req_address[2*16 +: 16] = 16'h0123;
        bus.req_read_request = 4'b0100;
        tick();
        check("t1_mstrobe", 32'(bus.mem_read_strobe), 32'd1);
        check("t1_maddr",   32'(bus.mem_address),     32'h0123);
        check("t1_grant",   32'(bus.grant),           32'd2);
        check("t1_busy",    32'(bus.busy),            32'd1);
        bus.req_read_request = 4'b0000;
        tick();
        check("t1_mstrobe_one_cycle", 32'(bus.mem_read_strobe), 32'd0);
        tick();
        tick();
        bus.mem_read_done = 1'b1;
        bus.mem_read_data = 16'hBEEF;
        check("t1_no_fin_early", 32'(bus.req_read_finished_strobe), 32'h0);
        tick();
        bus.mem_read_done = 1'b0;
        bus.mem_read_data = 16'h0000;
        check("t1_fin",  32'(bus.req_read_finished_strobe), 32'h4);
        check("t1_data", 32'(bus.req_read_data),            32'hBEEF);
        tick();
        check("t1_fin_one_cycle", 32'(bus.req_read_finished_strobe), 32'h0);
        check("t1_data_hold",     32'(bus.req_read_data),            32'hBEEF);
        check("t1_idle_busy",     32'(bus.busy),                     32'd0);

        // Reset again so channel 0 wins first, then all four request continuously
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) bus.req_address[i*16 +: 16] = 16'h1000 + 16'(i);
        bus.req_read_request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_strobe(20);
            check("rr_grant", 32'(bus.grant),       32'(k % 4));
            check("rr_maddr", 32'(bus.mem_address), 32'h1000 + 32'(k % 4));
            tick();
            bus.mem_read_done = 1'b1;
            bus.mem_read_data = 16'hA000 + 16'(k);
            tick();
            bus.mem_read_done = 1'b0;
            check("rr_fin",  32'(bus.req_read_finished_strobe), 32'(1) << (k % 4));
            check("rr_data", 32'(bus.req_read_data),            32'hA000 + 32'(k));
        end

        // Done in the same WAIT cycle that the timeout would expire (8th)
        bus.req_read_request = 4'b0010;
        wait_strobe(20);
        check("exp_grant", 32'(bus.grant), 32'd1);
        bus.req_read_request = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
        bus.mem_read_done = 1'b1;
        bus.mem_read_data = 16'h5A5A;
        check("exp_busy_in_wait8", 32'(bus.busy), 32'd1);
        tick();
        bus.mem_read_done = 1'b0;
        check("exp_fin",     32'(bus.req_read_finished_strobe), 32'h2);
        check("exp_data",    32'(bus.req_read_data),            32'h5A5A);
        check("exp_timeout", 32'(bus.timeout_error),            32'd0);

        // Memory never responds: timeout after 8 WAIT cycles, then next channel
        bus.req_read_request = 4'b1100;
        wait_strobe(20);
        check("to_grant", 32'(bus.grant), 32'd2);
        r_fin_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            r_fin_seen = r_fin_seen | (|bus.req_read_finished_strobe);
        end
        check("to_not_yet", 32'(bus.timeout_error), 32'd0);
        tick();
        r_fin_seen = r_fin_seen | (|bus.req_read_finished_strobe);
        check("to_flag",    32'(bus.timeout_error),   32'd1);
        check("to_busy",    32'(bus.busy),            32'd0);
        check("to_mstrobe", 32'(bus.mem_read_strobe), 32'd0);
        check("to_no_fin",  32'(r_fin_seen),          32'd0);
        tick();
        bus.req_read_request = 4'b0000;
        check("to_next_mstrobe", 32'(bus.mem_read_strobe), 32'd1);
        check("to_next_grant",   32'(bus.grant),           32'd3);
        check("to_next_maddr",   32'(bus.mem_address),     32'h1003);
        tick();
        bus.mem_read_done = 1'b1;
        bus.mem_read_data = 16'h7E57;
        tick();
        bus.mem_read_done = 1'b0;
        check("to_next_fin",   32'(bus.req_read_finished_strobe), 32'h8);
        check("to_next_data",  32'(bus.req_read_data),            32'h7E57);
        check("to_sticky",     32'(bus.timeout_error),            32'd1);

        // Reset during WAIT, then a late done after release
        bus.req_read_request = 4'b0001;
        wait_strobe(20);
        check("rw_grant_wrap", 32'(bus.grant), 32'd0);
        bus.req_read_request = 4'b0000;
        tick();
        tick();
        check("rw_in_wait", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rw_async");
        tick();
        rst = 1'b1;
        bus.mem_read_done = 1'b1;
        bus.mem_read_data = 16'hDEAD;
        tick();
        bus.mem_read_done = 1'b0;
        r_fin_seen = |bus.req_read_finished_strobe;
        for (int i = 0; i < 3; i++) begin
            tick();
            r_fin_seen = r_fin_seen | (|bus.req_read_finished_strobe);
        end
        check("rw_no_fin", 32'(r_fin_seen), 32'd0);
        check_reset_outputs("rw_after");

        // Address changed and request dropped while the read is in WAIT
        bus.req_address[1*16 +: 16] = 16'h0777;
        bus.req_read_request = 4'b0010;
        wait_strobe(20);
        check("ac_grant", 32'(bus.grant),       32'd1);
        check("ac_maddr", 32'(bus.mem_address), 32'h0777);
        bus.req_address[1*16 +: 16] = 16'h0F0F;
        bus.req_read_request = 4'b0000;
        tick();
        tick();
        check("ac_maddr_held", 32'(bus.mem_address), 32'h0777);
        bus.mem_read_done = 1'b1;
        bus.mem_read_data = 16'h1234;
        tick();
        bus.mem_read_done = 1'b0;
        check("ac_fin",  32'(bus.req_read_finished_strobe), 32'h2);
        check("ac_data", 32'(bus.req_read_data),            32'h1234);
        tick();
        check("ac_idle_busy", 32'(bus.busy),          32'd0);
        check("ac_data_hold", 32'(bus.req_read_data), 32'h1234);

        // Stray done while IDLE is ignored
        bus.mem_read_done = 1'b1;
        bus.mem_read_data = 16'h9999;
        tick();
        bus.mem_read_done = 1'b0;
        tick();
        check("stray_data", 32'(bus.req_read_data),            32'h1234);
        check("stray_fin",  32'(bus.req_read_finished_strobe), 32'h0);
        check("stray_busy", 32'(bus.busy),                     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
